// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared ALU opcodes and the registered operand bundle
package alu_arbiter_pkg;
    localparam logic [3:0] EXE_ALU_ADD = 4'd0;
    localparam logic [3:0] EXE_ALU_SUB = 4'd1;
    localparam logic [3:0] EXE_ALU_SLT = 4'd2;
    localparam logic [3:0] EXE_ALU_LUI = 4'd3;
    localparam logic [3:0] EXE_ALU_AND = 4'd4;
    localparam logic [3:0] EXE_ALU_OR  = 4'd5;
    localparam logic [3:0] EXE_ALU_XOR = 4'd6;
    localparam logic [3:0] EXE_ALU_SLL = 4'd7;
    localparam logic [3:0] EXE_ALU_SRL = 4'd8;
    localparam logic [3:0] EXE_ALU_SRA = 4'd9;
    localparam logic [3:0] EXE_ALU_ROT = 4'd10;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] a;
        logic [31:0] b;
        logic        sign;
        logic [3:0]  oper;
    } alu_op_t;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant; ptr only breaks ties
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic       gnt_id,
    output logic       gnt_valid
);
    assign gnt_valid = |valid;
    assign gnt_id    = (valid == 2'b11) ? ptr : valid[1];
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, one transaction in flight
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit PRIO_INIT = 1'b0,
    parameter int COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [31:0]        req0_inst,
    input  logic [31:0]        req0_a,
    input  logic [31:0]        req0_b,
    input  logic               req0_sign,
    input  logic [3:0]         req0_oper,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [31:0]        req1_inst,
    input  logic [31:0]        req1_a,
    input  logic [31:0]        req1_b,
    input  logic               req1_sign,
    input  logic [3:0]         req1_oper,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [31:0]        rsp0_result,
    output logic               rsp0_overflow,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [31:0]        rsp1_result,
    output logic               rsp1_overflow,
    output logic [31:0]        alu_inst,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic               alu_sign,
    output logic [3:0]         alu_oper,
    input  logic [31:0]        alu_result,
    input  logic               alu_overflow,
    output logic               busy,
    output logic [COUNT_W-1:0] ops_done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               gid_q, gid_d;
    alu_op_t            op_q, op_d;
    logic [31:0]        res_q, res_d;
    logic               ovf_q, ovf_d;
    logic [COUNT_W-1:0] ops_q, ops_d;
    logic               gnt_id, gnt_valid, rsp_ready, idle, resp;

    rr_arb2 u_arb (
        .valid     ({req1_valid, req0_valid}),
        .ptr       (ptr_q),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    assign idle      = state_q == IDLE;
    assign resp      = state_q == RESP;
    assign rsp_ready = gid_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        op_d    = op_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        ops_d   = ops_q;
        case (state_q)
            IDLE: if (gnt_valid) begin
                op_d    = gnt_id ? alu_op_t'({req1_inst, req1_a, req1_b, req1_sign, req1_oper})
                                 : alu_op_t'({req0_inst, req0_a, req0_b, req0_sign, req0_oper});
                gid_d   = gnt_id;
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = alu_result;
                ovf_d   = alu_overflow;
                state_d = RESP;
            end
            RESP: if (rsp_ready) begin
                ops_d   = ops_q + COUNT_W'(1);
                ptr_d   = ~gid_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= PRIO_INIT;
            gid_q   <= 1'b0;
            op_q    <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            op_q    <= op_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            ops_q   <= ops_d;
        end
    end

    assign req0_ready    = idle & gnt_valid & ~gnt_id;
    assign req1_ready    = idle & gnt_valid & gnt_id;
    assign rsp0_valid    = resp & ~gid_q;
    assign rsp1_valid    = resp & gid_q;
    assign rsp0_result   = res_q;
    assign rsp1_result   = res_q;
    assign rsp0_overflow = ovf_q;
    assign rsp1_overflow = ovf_q;
    assign alu_inst      = op_q.inst;
    assign alu_a         = op_q.a;
    assign alu_b         = op_q.b;
    assign alu_sign      = op_q.sign;
    assign alu_oper      = op_q.oper;
    assign busy          = ~idle;
    assign ops_done      = ops_q;
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational ALU between two requesters, typically the EXE stage (port 0) and the coprocessor/debug path (port 1). Uses round-robin arbitration and valid/ready handshakes on both the request and response sides. Operands are registered before they reach the ALU, and the result is registered on the way back. One transaction is in flight at a time; the block drives the shared ALU instance through its alu_* ports.

Parameters:
PRIO_INIT, 0, requester holding priority after reset (0 or 1)
COUNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
reqN_valid (N=0,1)  in  1  request N presents an operation
reqN_ready (N=0,1)  out  1  request N accepted this cycle
reqN_inst (N=0,1)  in  32  instruction word (shift amount, LUI immediate, rotate bits)
reqN_a, reqN_b (N=0,1)  in  32  operands
reqN_sign (N=0,1)  in  1  signed/unsigned flag
reqN_oper (N=0,1)  in  4  ALU operation code (EXE_ALU_*)
rspN_valid (N=0,1)  out  1  result available for requester N
rspN_ready (N=0,1)  in  1  requester N consumes result
rspN_result (N=0,1)  out  32  registered ALU result
rspN_overflow (N=0,1)  out  1  registered overflow flag
alu_inst, alu_a, alu_b  out  32 each  operands to shared ALU
alu_sign  out  1  sign flag to shared ALU
alu_oper  out  4  operation to shared ALU
alu_result  in  32  ALU result (combinational from alu_* outputs)
alu_overflow  in  1  ALU overflow flag
busy  out  1  high in any state other than IDLE
ops_done  out  COUNT_W  count of completed transactions; wraps

Behaviour:
- Reset values:
  - State IDLE; priority pointer = PRIO_INIT.
  - All reqN_ready, rspN_valid and busy = 0.
  - Operand registers (alu_*) = 0; result registers = 0; ops_done = 0.
- FSM state IDLE:
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the requester the pointer selects.
  - The granted reqN_ready is high combinationally in that same cycle; the handshake completes there.
  - Capture inst/a/b/sign/oper into the operand registers, record the grant id, go to EXEC.
  - reqN_ready is never high in any other state, and never high for both requesters.
- FSM state EXEC (one cycle):
  - alu_* are driven from the operand registers.
  - Capture alu_result/alu_overflow into the result registers; go to RESP.
- FSM state RESP:
  - rsp<grant>_valid = 1; the other requester's rsp valid = 0.
  - rspN_result/overflow hold stable until rsp<grant>_ready = 1.
  - On handshake: increment ops_done, set pointer = ~grant, go to IDLE.
  - rspN_ready on the non-granted port is ignored.
- Latency: request accepted in cycle T, response valid from T+2. Maximum throughput is one operation per 3 cycles.
- Pointer update:
  - The pointer changes only on response completion.
  - A lone requester is always served, regardless of the pointer.
  - Under contention, service alternates strictly 0,1,0,1…
- reqN_valid may drop before acceptance; nothing is latched.
- Request fields and valid changing while not accepted are don't-care.
- Reset during EXEC or RESP:
  - The transaction is discarded and no response is issued.
  - All registers return to their reset values on the next edge.
- ops_done wraps from 2^COUNT_W−1 to 0.
- The operand registers hold their last value in IDLE; alu_* outputs are not zeroed between transactions.

Decomposition:
- EXE_ALU_* operation codes come from the shared define header already used by the ALU.
- FSM state encodings (IDLE=2'd0, EXEC=2'd1, RESP=2'd2) are localparams in this module.
- One natural sub-module: rr_arb2, a combinational 2-way round-robin grant from valid[1:0] and the pointer, producing grant id and grant_valid.
- The alu itself is instantiated beside this block at the next level up, not inside it.

Test Plan:
- Port 0 only, ADD, a=5, b=7, sign=1 → req0_ready in cycle 0, rsp0_valid in cycle 2, result=12, overflow=0, ops_done=1.
- Both ports valid, PRIO_INIT=0 (port 0 SUB 3−5 signed; port 1 SLT 3,5 signed), rsp ready always high:
  - port 0 served first, result=0xFFFFFFFE.
  - port 1 accepted in the next IDLE cycle, result=1.
- Port 0 ADD 0x7FFFFFFF+1 signed → rsp0_overflow=1; same operation with sign=0 → overflow=0, result=0x80000000.
- Backpressure: hold rsp1_ready low 10 cycles after an LUI with inst[15:0]=0xABCD → rsp1_valid held, result=0xABCD0000 stable, no new request accepted while port 0 valid; released → port 0 accepted in the following IDLE.
- Assert rst during RESP of a port 0 operation → no response issued, both rsp valid=0, ops_done=0, pointer=PRIO_INIT; a following request completes normally.
- Both ports continuously valid for 8 transactions → grants alternate 0,1,0,1…, ops_done=8, never both reqN_ready high.
